// File: rtl/ani_scheduler_if.sv
// Button/playlist/display bundle between the animation scheduler and its surroundings.
// master drives the buttons, the loop-done pulse and playlist writes; slave is the scheduler.
interface ani_scheduler_if;
    logic        btn_next;
    logic        btn_prev;
    logic        btn_mode;
    logic        cycle_done;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [5:0]  animation;
    logic        anim_load;
    logic        auto_mode;
    logic [2:0]  entry_idx;

    modport master (
        output btn_next, btn_prev, btn_mode, cycle_done, wr_en, wr_addr, wr_data,
        input  animation, anim_load, auto_mode, entry_idx
    );

    modport slave (
        input  btn_next, btn_prev, btn_mode, cycle_done, wr_en, wr_addr, wr_data,
        output animation, anim_load, auto_mode, entry_idx
    );
endinterface

// File: rtl/ani_scheduler.sv
// Animation scheduler: manual stepping through animations or automatic playlist playback.
// Define ANI_SCHED_PRESET_EN to reset the playlist to a four-entry demo sequence.
module ani_scheduler #(
    parameter int ANI_MAX  = 50,
    parameter int PL_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    ani_scheduler_if.slave  bus
);

    localparam int         IDX_W     = 3;
    localparam int         ID_W      = 6;
    localparam logic [5:0] ANI_MAX_V = ID_W'(ANI_MAX);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Entry layout: [11:6] animation id, [5:0] repeat count (0 = end of list).
`ifdef ANI_SCHED_PRESET_EN
    localparam logic [11:0] PL_RESET [PL_DEPTH] = '{
        {6'd0,  6'd2}, {6'd5,  6'd2}, {6'd10, 6'd2}, {6'd20, 6'd2},
        12'd0, 12'd0, 12'd0, 12'd0
    };
`else
    localparam logic [11:0] PL_RESET [PL_DEPTH] = '{default: 12'd0};
`endif

    state_t             state_q, state_d;
    logic [ID_W-1:0]    animation_q, animation_d;
    logic [IDX_W-1:0]   entry_idx_q, entry_idx_d;
    logic               anim_load_q, anim_load_d;
    logic [5:0]         rep_cnt_q, rep_cnt_d;
    logic [11:0]        pl_q [PL_DEPTH];
    logic [11:0]        pl_d [PL_DEPTH];

    logic [IDX_W-1:0]   adv_idx;
    logic [IDX_W-1:0]   prev_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               prev_found;
    logic               list_empty;
    logic               do_load;
    logic [IDX_W-1:0]   load_idx;
    logic [5:0]         cur_rep;

    function automatic logic [ID_W-1:0] sat_id(input logic [ID_W-1:0] id);
        return (id > ANI_MAX_V) ? ANI_MAX_V : id;
    endfunction

    // Playlist navigation targets, computed from the pre-write playlist contents.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        list_empty = (pl_q[0][5:0] == 6'd0);
        cur_rep    = pl_q[entry_idx_q][5:0];

        adv_idx = entry_idx_q + 1'b1;
        if (pl_q[adv_idx][5:0] == 6'd0) begin
            adv_idx = '0;
        end

        // Walk backwards over end-of-list slots to the nearest populated entry.
        prev_idx   = entry_idx_q;
        prev_found = 1'b0;
        cand_idx   = entry_idx_q;
        for (int i = 1; i < PL_DEPTH; i++) begin
            cand_idx = entry_idx_q - IDX_W'(i);
            if (!prev_found && (pl_q[cand_idx][5:0] != 6'd0)) begin
                prev_idx   = cand_idx;
                prev_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        animation_d = animation_q;
        entry_idx_d = entry_idx_q;
        rep_cnt_d   = rep_cnt_q;
        anim_load_d = 1'b0;
        do_load     = 1'b0;
        load_idx    = entry_idx_q;

        pl_d = pl_q;
        if (bus.wr_en) begin
            pl_d[bus.wr_addr] = bus.wr_data;
        end

        unique case (state_q)
            MANUAL: begin
                if (bus.btn_mode) begin
                    if (!list_empty) begin
                        do_load  = 1'b1;
                        load_idx = '0;
                    end
                end else if (bus.btn_next) begin
                    animation_d = (animation_q >= ANI_MAX_V) ? '0 : animation_q + 1'b1;
                    anim_load_d = 1'b1;
                end else if (bus.btn_prev) begin
                    animation_d = (animation_q == '0) ? ANI_MAX_V : animation_q - 1'b1;
                    anim_load_d = 1'b1;
                end
            end
            AUTO: begin
                if (bus.btn_mode) begin
                    state_d   = MANUAL;
                    rep_cnt_d = '0;
                end else if (bus.btn_next) begin
                    do_load  = 1'b1;
                    load_idx = adv_idx;
                end else if (bus.btn_prev) begin
                    do_load  = 1'b1;
                    load_idx = prev_idx;
                end else if (bus.cycle_done) begin
                    // Widened compare so a repeat of 63 cannot overflow the counter.
                    if (({1'b0, rep_cnt_q} + 7'd1) < {1'b0, cur_rep}) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end else begin
                        do_load  = 1'b1;
                        load_idx = adv_idx;
                    end
                end
            end
            default: state_d = MANUAL;
        endcase

        // A load with an empty playlist falls back to manual and keeps the current picture.
        if (do_load) begin
            rep_cnt_d = '0;
            if (list_empty) begin
                state_d = MANUAL;
            end else begin
                state_d     = AUTO;
                entry_idx_d = load_idx;
                animation_d = sat_id(pl_q[load_idx][11:6]);
                anim_load_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MANUAL;
            animation_q <= '0;
            entry_idx_q <= '0;
            anim_load_q <= 1'b0;
            rep_cnt_q   <= '0;
            // NOTE: the playlist is reset because auto entry reads entry 0 right after reset.
            pl_q        <= PL_RESET;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q     <= state_d;
            animation_q <= animation_d;
            entry_idx_q <= entry_idx_d;
            anim_load_q <= anim_load_d;
            rep_cnt_q   <= rep_cnt_d;
            pl_q        <= pl_d;
        end
    end

    assign bus.animation = animation_q;
    assign bus.anim_load = anim_load_q;
    assign bus.auto_mode = (state_q == AUTO);
    assign bus.entry_idx = entry_idx_q;

endmodule

// File: tb/tb_ani_scheduler.sv
// Directed bench for ani_scheduler (default build, empty playlist after reset).
// Inputs change 1 ns after a rising edge; outputs are compared at that same point.
module tb_ani_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ani_scheduler_if bus ();

    ani_scheduler #(
        .ANI_MAX (50),
        .PL_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.btn_next   = 1'b0;
        bus.btn_prev   = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.cycle_done = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 3'd0;
        bus.wr_data    = 12'd0;
    endtask

    // Advance one clock with whatever inputs are currently driven, then release them.
    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic write_entry(input logic [2:0] addr, input logic [5:0] id, input logic [5:0] rep);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = {id, rep};
        step();
    endtask

    task automatic expect_out(input string tag, input int anim, input int load,
                              input int auto_m, input int idx);
        check({tag, ".animation"}, 32'(bus.animation), anim);
        check({tag, ".anim_load"}, 32'(bus.anim_load), load);
        check({tag, ".auto_mode"}, 32'(bus.auto_mode), auto_m);
        check({tag, ".entry_idx"}, 32'(bus.entry_idx), idx);
    endtask

    initial begin
        int exp_anim;
        checks = 0;
        errors = 0;
        clear_inputs();
        reset = 1'b1;
        #2;
        expect_out("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_reset", 0, 0, 0, 0);

        // Empty playlist: mode press must not enter auto.
        bus.btn_mode = 1'b1;
        step();
        expect_out("empty_mode", 0, 0, 0, 0);

        // Manual wrap through all 51 indices.
        exp_anim = 0;
        for (int i = 0; i < 51; i++) begin
            bus.btn_next = 1'b1;
            step();
            exp_anim = (exp_anim == 50) ? 0 : exp_anim + 1;
            check("wrap.animation", 32'(bus.animation), exp_anim);
            check("wrap.anim_load", 32'(bus.anim_load), 1);
        end
        check("wrap.final", 32'(bus.animation), 0);
        step();
        check("idle.anim_load", 32'(bus.anim_load), 0);

        bus.btn_prev = 1'b1;
        step();
        expect_out("prev_wrap", 50, 1, 0, 0);
        bus.btn_prev = 1'b1;
        step();
        expect_out("prev_dec", 49, 1, 0, 0);
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        step();
        expect_out("next_over_prev", 50, 1, 0, 0);
        bus.cycle_done = 1'b1;
        step();
        expect_out("manual_cycle_done", 50, 0, 0, 0);

        // Playback of a two-entry list.
        write_entry(3'd0, 6'd3, 6'd1);
        write_entry(3'd1, 6'd7, 6'd2);
        write_entry(3'd2, 6'd0, 6'd0);
        check("write_no_effect", 32'(bus.animation), 50);
        bus.btn_mode = 1'b1;
        step();
        expect_out("auto_enter", 3, 1, 1, 0);
        step();
        expect_out("auto_idle", 3, 0, 1, 0);
        bus.cycle_done = 1'b1;
        step();
        expect_out("auto_e0_done", 7, 1, 1, 1);
        bus.cycle_done = 1'b1;
        step();
        expect_out("auto_e1_rep1", 7, 0, 1, 1);
        bus.cycle_done = 1'b1;
        step();
        expect_out("auto_wrap_e0", 3, 1, 1, 0);

        // Mode beats a simultaneous cycle_done.
        bus.btn_mode   = 1'b1;
        bus.cycle_done = 1'b1;
        step();
        expect_out("collision", 3, 0, 0, 0);

        // Skip forward/back in auto.
        bus.btn_mode = 1'b1;
        step();
        expect_out("auto_reenter", 3, 1, 1, 0);
        bus.btn_next = 1'b1;
        step();
        expect_out("auto_next", 7, 1, 1, 1);
        bus.btn_prev = 1'b1;
        step();
        expect_out("auto_prev", 3, 1, 1, 0);
        bus.btn_prev = 1'b1;
        step();
        expect_out("auto_prev_skip", 7, 1, 1, 1);
        write_entry(3'd1, 6'd12, 6'd2);
        expect_out("write_current", 7, 0, 1, 1);
        bus.btn_next = 1'b1;
        step();
        expect_out("auto_next_wrap", 3, 1, 1, 0);
        bus.btn_next   = 1'b1;
        bus.cycle_done = 1'b1;
        step();
        expect_out("auto_next_new", 12, 1, 1, 1);

        // Saturation and the single-entry back-skip.
        bus.btn_mode = 1'b1;
        step();
        expect_out("to_manual", 12, 0, 0, 1);
        write_entry(3'd0, 6'd63, 6'd1);
        write_entry(3'd1, 6'd9, 6'd0);
        bus.btn_mode = 1'b1;
        step();
        expect_out("sat_enter", 50, 1, 1, 0);
        bus.btn_prev = 1'b1;
        step();
        expect_out("sat_prev", 50, 1, 1, 0);

        // Emptied list while playing: advance drops to manual.
        write_entry(3'd0, 6'd4, 6'd0);
        bus.cycle_done = 1'b1;
        step();
        expect_out("empty_advance", 50, 0, 0, 0);

        // Reset while playing entry 1.
        write_entry(3'd0, 6'd4, 6'd1);
        write_entry(3'd1, 6'd6, 6'd1);
        bus.btn_mode = 1'b1;
        step();
        expect_out("pre_reset_e0", 4, 1, 1, 0);
        bus.cycle_done = 1'b1;
        step();
        expect_out("pre_reset_e1", 6, 1, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b1;
        step();
        expect_out("mode_after_reset", 0, 0, 0, 0);
        bus.btn_next = 1'b1;
        step();
        expect_out("next_after_reset", 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ani_scheduler.md
ANI_SCHEDULER -- requirements
Module: ani_scheduler

Interface
REQ-001 Parameter ANI_MAX, default 50, highest valid animation index; manual stepping wraps at it.
REQ-002 Parameter PL_DEPTH, default 8, playlist entries; fixed power of two; index width 3.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_next  input  1  one-cycle debounced pulse: next animation (manual) or skip to next entry (auto).
REQ-006 btn_prev  input  1  one-cycle debounced pulse: previous animation (manual) or previous entry (auto).
REQ-007 btn_mode  input  1  one-cycle pulse toggling manual/auto.
REQ-008 cycle_done  input  1  one-cycle pulse from the display datapath when its digit counter wraps (one animation loop finished).
REQ-009 wr_en  input  1  playlist write strobe.
REQ-010 wr_addr  input  3  playlist entry written.
REQ-011 wr_data  input  12  [11:6] animation id, [5:0] repeat count; repeat 0 marks end of list.
REQ-012 animation  output  6  registered animation index to the display datapath.
REQ-013 anim_load  output  1  registered one-cycle pulse when animation is (re)loaded; datapath clears its digit counter.
REQ-014 auto_mode  output  1  high in AUTO state.
REQ-015 entry_idx  output  3  current playlist entry (meaningful in AUTO).

Function
REQ-016 Two states: MANUAL, AUTO; state, animation, entry_idx, anim_load, repeat counter rep_cnt (6 bits) are registers; outputs change one cycle after the triggering input.
REQ-017 Per-cycle input priority: btn_mode > btn_next > btn_prev > cycle_done; lower-priority events in the same cycle are dropped.
REQ-018 MANUAL, btn_next: animation+1, ANI_MAX wraps to 0; btn_prev: animation-1, 0 wraps to ANI_MAX; anim_load=1; cycle_done ignored.
REQ-019 MANUAL, btn_mode: if entry 0 repeat != 0 -> AUTO, entry_idx=0, rep_cnt=0, animation=entry 0 id, anim_load=1; else stay MANUAL, no output change.
REQ-020 AUTO, cycle_done: if rep_cnt+1 < entry repeat then rep_cnt+1, no load; else advance (REQ-021).
REQ-021 Advance: n=(entry_idx+1) mod 8; if entry n repeat==0 then n=0; if entry 0 repeat==0 -> MANUAL, animation held, anim_load=0; otherwise entry_idx=n, rep_cnt=0, animation=entry n id, anim_load=1.
REQ-022 AUTO, btn_next: advance per REQ-021 regardless of rep_cnt.
REQ-023 AUTO, btn_prev: n=entry_idx-1 mod 8, stepping further back over repeat-0 entries (max 7 steps) to the nearest non-zero entry; load as REQ-021.
REQ-024 AUTO, btn_mode: -> MANUAL, animation held, rep_cnt=0, no anim_load.
REQ-025 Loaded playlist ids above ANI_MAX saturate to ANI_MAX.
REQ-026 Playlist writes accepted in any state; a write to the current entry does not alter animation until the next load; a read of an entry written in the same cycle returns the old value.
REQ-027 anim_load never high two consecutive cycles without a new qualifying event each cycle.

Reset
REQ-028 reset asserted: state=MANUAL, animation=0, anim_load=0, auto_mode=0, entry_idx=0, rep_cnt=0, playlist per REQ-030/031, immediately and independent of clk.
REQ-029 Reset mid-AUTO discards rep_cnt and position; first cycle after release accepts inputs normally.

Configuration
REQ-030 With ANI_SCHED_PRESET_EN defined, reset loads entries 0-3 = (id 0, rep 2), (id 5, rep 2), (id 10, rep 2), (id 20, rep 2); entries 4-7 = 0.
REQ-031 Without ANI_SCHED_PRESET_EN, reset clears all entries to 0; auto entry requires prior writes.

Verification
REQ-032 Manual wrap: reset, 51 btn_next pulses -> animation 1..50 then 0, anim_load one pulse each; btn_prev at 0 -> 50.
REQ-033 Empty list (macro off): btn_mode after reset -> auto_mode stays 0, animation 0, no anim_load.
REQ-034 Playback: write (3,1),(7,2),(0,0) to entries 0-2, btn_mode -> animation 3; 1 cycle_done -> 7; 2 cycle_done -> 3, entry_idx 0.
REQ-035 Collision: btn_mode and cycle_done same cycle in AUTO -> MANUAL, animation held, no advance.
REQ-036 Saturation/skip: entry 0 = (63,1), entry 1 = (9,0): auto -> animation 50; btn_prev -> stays entry 0, animation 50, anim_load 1.
REQ-037 Reset mid-AUTO at entry 1 -> animation 0, auto_mode 0 asynchronously; preset (macro on) btn_mode -> animation 0, entry_idx 0.
